execute_stage: RTL

- Execute-side consumer of the decode/execute pipeline register.
- Takes the registered operands and control from that register and computes the ALU result.
- Runs an iterative multi-cycle multiply and produces the registered execute/memory pipeline outputs.
- Drives a `stall` back to the decode/execute register, so the register holds its contents while a multiply is in progress.

---
 rtl/execute_stage.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// execute_stage: execute-side consumer of the decode/execute pipeline register.
// Computes single-cycle ALU results in one edge and runs a shift-and-add multiply
// over DATA_W+1 edges, producing the registered execute/memory output bundle.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   flush               squash the presented instruction and any multiply in flight
//   in_valid, exe_cmd   instruction valid and operation code
//   val1, val2          operands A and B
//   st_val_in, dest_in  store data and writeback index, passed through
//   *_in control        mem_r_en/mem_w_en/wb_en/br_taken, passed through
//   stall               combinational; holds the decode/execute register
//   out_valid, alu_res, st_val, dest, mem_r_en, mem_w_en, wb_en, br_taken
//                       registered output bundle
module execute_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = 5,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic              br_taken_in,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_W-1:0]  dest,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic              br_taken
);

  localparam logic [3:0]      CmdMul  = 4'd9;
  localparam logic [SH_W-1:0] CntLast = SH_W'(DATA_W - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e state_q, state_d;

  // Output bundle registers; control is packed as {mem_r, mem_w, wb, br}.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [3:0]        ctrl_q, ctrl_d;

  // Multiplier state and the fields captured at multiply start.
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_st_q, cap_st_d;
  logic [REG_W-1:0]  cap_dest_q, cap_dest_d;
  logic [3:0]        cap_ctrl_q, cap_ctrl_d;

  logic [3:0]        ctrl_in;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] partial;
  logic [DATA_W-1:0] acc_step;
  logic              is_mul;

  assign ctrl_in = {mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in};
  assign sh_amt  = val2[SH_W-1:0];
  assign is_mul  = (exe_cmd == CmdMul);

  // Single-cycle ALU.
  always_comb begin
    alu_out = '0;
    case (exe_cmd)
      4'd0:    alu_out = val1 + val2;
      4'd1:    alu_out = val1 - val2;
      4'd2:    alu_out = val1 & val2;
      4'd3:    alu_out = val1 | val2;
      4'd4:    alu_out = val1 ^ val2;
      4'd5:    alu_out = val1 << sh_amt;
      4'd6:    alu_out = val1 >> sh_amt;
      4'd7:    alu_out = $unsigned($signed(val1) >>> sh_amt);
      4'd8:    alu_out = {{(DATA_W-1){1'b0}}, ($signed(val1) < $signed(val2))};
      4'd10:   alu_out = val2;
      default: alu_out = '0;
    endcase
  end

  // One shift-and-add step; the final step's sum goes straight to alu_res.
  assign partial  = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
  assign acc_step = acc_q + partial;

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (in_valid && is_mul) state_d = StMul;
        StMul:  if (cnt_q == CntLast) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs. Stall is forced low while reset is held.
  always_comb begin
    stall = 1'b0;
    if (rst && !flush) begin
      unique case (state_q)
        StIdle:  stall = in_valid && is_mul;
        StMul:   stall = (cnt_q != CntLast);
        default: stall = 1'b0;
      endcase
    end
  end

  // Datapath next state. Default is a bubble: valid and control clear, data held.
  always_comb begin
    out_valid_d = 1'b0;
    ctrl_d      = '0;
    alu_d       = alu_q;
    st_d        = st_q;
    dest_d      = dest_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cap_st_d    = cap_st_q;
    cap_dest_d  = cap_dest_q;
    cap_ctrl_d  = cap_ctrl_q;
    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && is_mul) begin
            mcand_d    = val1;
            mplier_d   = val2;
            acc_d      = '0;
            cnt_d      = '0;
            cap_st_d   = st_val_in;
            cap_dest_d = dest_in;
            cap_ctrl_d = ctrl_in;
          end else if (in_valid) begin
            out_valid_d = 1'b1;
            alu_d       = alu_out;
            st_d        = st_val_in;
            dest_d      = dest_in;
            ctrl_d      = ctrl_in;
          end
        end
        StMul: begin
          acc_d = acc_step;
          cnt_d = cnt_q + SH_W'(1);
          if (cnt_q == CntLast) begin
            out_valid_d = 1'b1;
            alu_d       = acc_step;
            st_d        = cap_st_q;
            dest_d      = cap_dest_q;
            ctrl_d      = cap_ctrl_q;
            cnt_d       = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      st_q        <= '0;
      dest_q      <= '0;
      ctrl_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cap_st_q    <= '0;
      cap_dest_q  <= '0;
      cap_ctrl_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      st_q        <= st_d;
      dest_q      <= dest_d;
      ctrl_q      <= ctrl_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cap_st_q    <= cap_st_d;
      cap_dest_q  <= cap_dest_d;
      cap_ctrl_q  <= cap_ctrl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_res   = alu_q;
  assign st_val    = st_q;
  assign dest      = dest_q;
  assign mem_r_en  = ctrl_q[3];
  assign mem_w_en  = ctrl_q[2];
  assign wb_en     = ctrl_q[1];
  assign br_taken  = ctrl_q[0];

endmodule
